// File: rtl/dvi_timing_ctrl.sv
// DVI raster timing generator: walks the h/v raster, requests pixels from an
// upstream source and re-times de/hsync/vsync/sof to match the returned data.
module dvi_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_LAT  = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    output logic            pix_req_o,
    output logic [11:0]     x_o,
    output logic [11:0]     y_o,
    input  logic [2:0][7:0] pixel_i,
    output logic            de_o,
    output logic            hsync_o,
    output logic            vsync_o,
    output logic [2:0][7:0] pixel_o,
    output logic            sof_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 4096 || V_TOTAL > 4096 || PIX_LAT < 0 || PIX_LAT > 4) begin : g_param_check
        $error("dvi_timing_ctrl: raster totals must be <= 4096 and PIX_LAT within 0..4");
    end

    // Window bounds are 13 bits wide because a bound may equal 4096.
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
    localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
    localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [12:0] h_ext;
    logic [12:0] v_ext;
    logic        hs_raw;
    logic        vs_raw;
    logic        sof_raw;
    logic [3:0]  stage0;
    logic [3:0]  tap;

    assign h_ext = {1'b0, h_cnt};
    assign v_ext = {1'b0, v_cnt};

    // Dropping en_i parks the raster at the origin so a restart begins a fresh frame.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pix_req_o <= 1'b0;
            x_o       <= '0;
            y_o       <= '0;
            hs_raw    <= 1'b0;
            vs_raw    <= 1'b0;
            sof_raw   <= 1'b0;
        end else begin
            x_o       <= h_cnt;
            y_o       <= v_cnt;
            pix_req_o <= en_i && (h_ext < H_ACT) && (v_ext < V_ACT);
            hs_raw    <= en_i && (h_ext >= HS_START) && (h_ext < HS_END);
            vs_raw    <= en_i && (v_ext >= VS_START) && (v_ext < VS_END);
            sof_raw   <= en_i && (h_cnt == 12'd0) && (v_cnt == 12'd0);
        end
    end

    assign stage0 = {pix_req_o, hs_raw, vs_raw, sof_raw};

    // Timing flags travel through as many stages as the source takes to answer.
    if (PIX_LAT == 0) begin : g_no_delay
        assign tap = stage0;
    end else begin : g_delay
        logic [3:0] dly [PIX_LAT];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < PIX_LAT; i++) begin
                    dly[i] <= '0;
                end
            end else begin
                dly[0] <= stage0;
                for (int i = 1; i < PIX_LAT; i++) begin
                    dly[i] <= dly[i-1];
                end
            end
        end

        assign tap = dly[PIX_LAT-1];
    end

    assign de_o    = tap[3];
    assign hsync_o = tap[2] ~^ HS_POL;
    assign vsync_o = tap[1] ~^ VS_POL;
    assign sof_o   = tap[0];
    assign pixel_o = de_o ? pixel_i : '0;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Directed bench for dvi_timing_ctrl: a default 640x480 instance (PIX_LAT=1)
// and two tiny-raster instances (PIX_LAT=3 and PIX_LAT=0, positive syncs).
module tb_dvi_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic en;

    logic            pix_req_a, de_a, hs_a, vs_a, sof_a;
    logic [11:0]     x_a, y_a;
    logic [2:0][7:0] pixin_a, pixout_a;

    logic            pix_req_b, de_b, hs_b, vs_b, sof_b;
    logic [11:0]     x_b, y_b;
    logic [2:0][7:0] pixin_b, pixout_b, pb1, pb2, pb3;

    logic            pix_req_c, de_c, hs_c, vs_c, sof_c;
    logic [11:0]     x_c, y_c;
    logic [2:0][7:0] pixin_c, pixout_c;

    int n_cmp;
    int n_err;

    dvi_timing_ctrl u_dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .pix_req_o(pix_req_a), .x_o(x_a), .y_o(y_a), .pixel_i(pixin_a),
        .de_o(de_a), .hsync_o(hs_a), .vsync_o(vs_a), .pixel_o(pixout_a), .sof_o(sof_a)
    );

    dvi_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(3)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .pix_req_o(pix_req_b), .x_o(x_b), .y_o(y_b), .pixel_i(pixin_b),
        .de_o(de_b), .hsync_o(hs_b), .vsync_o(vs_b), .pixel_o(pixout_b), .sof_o(sof_b)
    );

    dvi_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(0)
    ) u_dut_c (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .pix_req_o(pix_req_c), .x_o(x_c), .y_o(y_c), .pixel_i(pixin_c),
        .de_o(de_c), .hsync_o(hs_c), .vsync_o(vs_c), .pixel_o(pixout_c), .sof_o(sof_c)
    );

    // Pixel sources answer {y,x,A5} after their latency; unrequested slots return all-ones.
    always @(posedge clk) begin
        pixin_a <= pix_req_a ? {y_a[7:0], x_a[7:0], 8'hA5} : 24'hFFFFFF;
        pb1     <= pix_req_b ? {y_b[7:0], x_b[7:0], 8'hA5} : 24'hFFFFFF;
        pb2     <= pb1;
        pb3     <= pb2;
    end
    assign pixin_b = pb3;
    assign pixin_c = pix_req_c ? {y_c[7:0], x_c[7:0], 8'hA5} : 24'hFFFFFF;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input int cycles);
        rst = r;
        en  = e;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, "_pix_req"}, 32'(pix_req_a), 32'd0);
        checkOutput({tag, "_x"},       32'(x_a),       32'd0);
        checkOutput({tag, "_y"},       32'(y_a),       32'd0);
        checkOutput({tag, "_de"},      32'(de_a),      32'd0);
        checkOutput({tag, "_sof"},     32'(sof_a),     32'd0);
        checkOutput({tag, "_hsync"},   32'(hs_a),      32'd1);
        checkOutput({tag, "_vsync"},   32'(vs_a),      32'd1);
        checkOutput({tag, "_pixel"},   32'(pixout_a),  32'd0);
    endtask

    initial begin
        int d, hh, vv, hb, vb, hc, vc;
        logic exp_de, exp_hs, exp_vs, exp_sof;
        int a_de_cnt, a_de_err, a_hs_cnt, a_hs_first, a_hs_err, a_vs_err, a_pix_err, a_sof_cnt;
        int b_de_cnt, b_hs_cnt, b_vs_cnt, b_sof_cnt, b_err, b_pix_err;
        int c_de_cnt, c_sof_cnt, c_err, c_pix_err;
        int sof_extra;

        n_cmp = 0;
        n_err = 0;
        a_de_cnt = 0; a_de_err = 0; a_hs_cnt = 0; a_hs_first = -1; a_hs_err = 0;
        a_vs_err = 0; a_pix_err = 0; a_sof_cnt = 0;
        b_de_cnt = 0; b_hs_cnt = 0; b_vs_cnt = 0; b_sof_cnt = 0; b_err = 0; b_pix_err = 0;
        c_de_cnt = 0; c_sof_cnt = 0; c_err = 0; c_pix_err = 0;
        sof_extra = 0;

        applyStimulus(1'b1, 1'b1, 2);
        checkResetA("por");
        checkOutput("por_b_hsync", 32'(hs_b), 32'd0);
        checkOutput("por_b_vsync", 32'(vs_b), 32'd0);
        checkOutput("por_b_de",    32'(de_b), 32'd0);

        rst = 1'b0;
        en  = 1'b1;
        for (int c = 0; c <= 900; c++) begin
            @(posedge clk);
            #1;

            // Default raster, outputs lag the request by one clock.
            if (c == 0) begin
                checkOutput("a_first_req", 32'(pix_req_a), 32'd1);
                checkOutput("a_first_x",   32'(x_a),       32'd0);
                checkOutput("a_first_y",   32'(y_a),       32'd0);
                checkOutput("a_first_de",  32'(de_a),      32'd0);
            end
            if (c == 1)   checkOutput("a_sof_first", 32'(sof_a),     32'd1);
            if (c == 640) checkOutput("a_req_end",   32'(pix_req_a), 32'd0);
            if (c == 799) checkOutput("a_x_last",    32'(x_a),       32'd799);
            if (c == 800) begin
                checkOutput("a_x_wrap", 32'(x_a), 32'd0);
                checkOutput("a_y_next", 32'(y_a), 32'd1);
            end
            if (c >= 1) begin
                d  = c - 1;
                hh = d % 800;
                vv = d / 800;
                exp_de = (hh < 640);
                exp_hs = (hh >= 656 && hh < 752);
                if (de_a !== exp_de) a_de_err++;
                if (de_a === 1'b1 && d < 800) a_de_cnt++;
                if (hs_a !== !exp_hs) a_hs_err++;
                if (hs_a === 1'b0) begin
                    if (d < 800) a_hs_cnt++;
                    if (a_hs_first < 0) a_hs_first = hh;
                end
                if (vs_a !== 1'b1) a_vs_err++;
                if (sof_a === 1'b1) a_sof_cnt++;
                if (de_a === 1'b1) begin
                    if (pixout_a !== {vv[7:0], hh[7:0], 8'hA5}) a_pix_err++;
                end else if (pixout_a !== 24'h0) begin
                    a_pix_err++;
                end
            end

            // Tiny raster with three clocks of source latency, two frames.
            if (c <= 98) begin
                if (c == 0) checkOutput("b_req_first", 32'(pix_req_b), 32'd1);
                if (c == 2) checkOutput("b_de_early",  32'(de_b),      32'd0);
                if (c == 3) checkOutput("b_de_lat3",   32'(de_b),      32'd1);
                if (c == 8) begin
                    checkOutput("b_x_wrap", 32'(x_b), 32'd0);
                    checkOutput("b_y_inc",  32'(y_b), 32'd1);
                end
                if (c == 47) begin
                    checkOutput("b_x_last", 32'(x_b), 32'd7);
                    checkOutput("b_y_last", 32'(y_b), 32'd5);
                end
                if (c == 48) checkOutput("b_y_wrap", 32'(y_b), 32'd0);
                d = c - 3;
                if (d >= 0) begin
                    hb = d % 8;
                    vb = (d / 8) % 6;
                    exp_de  = (hb < 4) && (vb < 3);
                    exp_hs  = (hb == 5) || (hb == 6);
                    exp_vs  = (vb == 4);
                    exp_sof = (hb == 0) && (vb == 0);
                end else begin
                    hb = 0; vb = 0;
                    exp_de = 1'b0; exp_hs = 1'b0; exp_vs = 1'b0; exp_sof = 1'b0;
                end
                if (de_b !== exp_de || hs_b !== exp_hs || vs_b !== exp_vs || sof_b !== exp_sof) b_err++;
                if (de_b === 1'b1) b_de_cnt++;
                if (hs_b === 1'b1) b_hs_cnt++;
                if (vs_b === 1'b1) b_vs_cnt++;
                if (sof_b === 1'b1) b_sof_cnt++;
                if (de_b === 1'b1) begin
                    if (pixout_b !== {vb[7:0], hb[7:0], 8'hA5}) b_pix_err++;
                end else if (pixout_b !== 24'h0) begin
                    b_pix_err++;
                end
            end

            // Tiny raster with zero latency: timing coincides with the request.
            if (c <= 95) begin
                hc = c % 8;
                vc = (c / 8) % 6;
                if (c == 0) begin
                    checkOutput("c_sof_first", 32'(sof_c), 32'd1);
                    checkOutput("c_de_first",  32'(de_c),  32'd1);
                end
                if (de_c !== pix_req_c) c_err++;
                if (sof_c === 1'b1 && de_c !== 1'b1) c_err++;
                if (de_c === 1'b1) c_de_cnt++;
                if (sof_c === 1'b1) c_sof_cnt++;
                if (de_c === 1'b1) begin
                    if (pixout_c !== {vc[7:0], hc[7:0], 8'hA5}) c_pix_err++;
                end else if (pixout_c !== 24'h0) begin
                    c_pix_err++;
                end
            end
        end

        checkOutput("a_de_line0",   32'(a_de_cnt),   32'd640);
        checkOutput("a_de_pattern", 32'(a_de_err),   32'd0);
        checkOutput("a_hs_width",   32'(a_hs_cnt),   32'd96);
        checkOutput("a_hs_start",   32'(a_hs_first), 32'd656);
        checkOutput("a_hs_pattern", 32'(a_hs_err),   32'd0);
        checkOutput("a_vs_idle",    32'(a_vs_err),   32'd0);
        checkOutput("a_sof_count",  32'(a_sof_cnt),  32'd1);
        checkOutput("a_pixels",     32'(a_pix_err),  32'd0);
        checkOutput("b_de_count",   32'(b_de_cnt),   32'd24);
        checkOutput("b_hs_count",   32'(b_hs_cnt),   32'd24);
        checkOutput("b_vs_count",   32'(b_vs_cnt),   32'd16);
        checkOutput("b_sof_count",  32'(b_sof_cnt),  32'd2);
        checkOutput("b_pattern",    32'(b_err),      32'd0);
        checkOutput("b_pixels",     32'(b_pix_err),  32'd0);
        checkOutput("c_de_count",   32'(c_de_cnt),   32'd24);
        checkOutput("c_sof_count",  32'(c_sof_cnt),  32'd2);
        checkOutput("c_pattern",    32'(c_err),      32'd0);
        checkOutput("c_pixels",     32'(c_pix_err),  32'd0);

        // Enable dropped while (100,1) is on stage 0.
        checkOutput("drop_x", 32'(x_a), 32'd100);
        checkOutput("drop_y", 32'(y_a), 32'd1);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("drop_req_idle", 32'(pix_req_a), 32'd0);
        checkOutput("drop_de_still", 32'(de_a),      32'd1);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("drop_de_idle",  32'(de_a),     32'd0);
        checkOutput("drop_hs_idle",  32'(hs_a),     32'd1);
        checkOutput("drop_pix_zero", 32'(pixout_a), 32'd0);
        applyStimulus(1'b0, 1'b0, 8);
        checkOutput("drop_hold_req", 32'(pix_req_a), 32'd0);
        checkOutput("drop_hold_de",  32'(de_a),      32'd0);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("restart_req", 32'(pix_req_a), 32'd1);
        checkOutput("restart_x",   32'(x_a),       32'd0);
        checkOutput("restart_y",   32'(y_a),       32'd0);
        checkOutput("restart_sof_early", 32'(sof_a), 32'd0);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("restart_sof",   32'(sof_a),    32'd1);
        checkOutput("restart_de",    32'(de_a),     32'd1);
        checkOutput("restart_pixel", 32'(pixout_a), 32'h0000A5);
        checkOutput("restart_x1",    32'(x_a),      32'd1);
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'b0, 1'b1, 1);
            if (sof_a === 1'b1) sof_extra++;
        end
        checkOutput("restart_sof_once", 32'(sof_extra), 32'd0);

        // One-clock reset in the middle of an active line.
        applyStimulus(1'b1, 1'b1, 1);
        checkResetA("midrst");
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("post_rst_req", 32'(pix_req_a), 32'd1);
        checkOutput("post_rst_x",   32'(x_a),       32'd0);
        checkOutput("post_rst_y",   32'(y_a),       32'd0);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("post_rst_sof", 32'(sof_a), 32'd1);
        checkOutput("post_rst_de",  32'(de_a),  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
